sw_led_ctrl: RTL and testbench

- Parametrised successor to the board's switch-to-LED block; drives the stick's LEDs from NUM_CH push switches.
- Each channel has:
  - a 2-flop synchroniser
  - a per-channel debounce counter
  - a press detector
  - a 3-state LED mode FSM (OFF -> ON -> BLINK -> OFF), advanced on each debounced press
- A shared free-running divider provides the blink phase and a heartbeat LED.

---
 rtl/sw_led_ctrl.sv | 103 ++++++++++
 tb/tb_sw_led_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sw_led_ctrl.sv
// Per-channel switch conditioning (sync, debounce, press detect) driving a
// three-mode LED FSM, plus a shared free-running blink divider and heartbeat.
module sw_led_ctrl #(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BLINK_DIV_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     sw,
    output logic [NUM_CH-1:0]     led,
    output logic                  led_hb,
    output logic [NUM_CH-1:0]     press_pulse,
    output logic [2*NUM_CH-1:0]   mode
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;

    logic [BLINK_DIV_W-1:0] div_reg;
    logic                   led_hb_reg;
    logic                   phase;

    assign phase  = div_reg[BLINK_DIV_W-1];
    assign led_hb = led_hb_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg    <= '0;
            led_hb_reg <= 1'b0;
        end else begin
            div_reg    <= div_reg + BLINK_DIV_W'(1);
            led_hb_reg <= phase;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic             s1_reg;
            logic             s2_reg;
            logic             db_reg;
            logic             db_prev_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic [1:0]       mode_reg;
            logic [1:0]       mode_next;
            logic             pulse_reg;
            logic             led_reg;
            logic             rise;

            assign rise = db_reg & ~db_prev_reg;

            always_comb begin
                mode_next = mode_reg;
                if (rise) begin
                    case (mode_reg)
                        MODE_OFF:   mode_next = MODE_ON;
                        MODE_ON:    mode_next = MODE_BLINK;
                        default:    mode_next = MODE_OFF;
                    endcase
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_reg      <= 1'b0;
                    s2_reg      <= 1'b0;
                    db_reg      <= 1'b0;
                    db_prev_reg <= 1'b0;
                    cnt_reg     <= '0;
                    mode_reg    <= MODE_OFF;
                    pulse_reg   <= 1'b0;
                    led_reg     <= 1'b0;
                end else begin
                    s1_reg      <= sw[gi];
                    s2_reg      <= s1_reg;
                    db_prev_reg <= db_reg;
                    // Any sample agreeing with the accepted level restarts the run.
                    if (s2_reg == db_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        db_reg  <= s2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                    pulse_reg <= rise;
                    mode_reg  <= mode_next;
                    led_reg   <= (mode_reg == MODE_ON) | ((mode_reg == MODE_BLINK) & phase);
                end
            end

            assign led[gi]            = led_reg;
            assign press_pulse[gi]    = pulse_reg;
            assign mode[2*gi+1:2*gi]  = mode_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sw_led_ctrl.sv
// Directed bench for sw_led_ctrl at default parameters; one line per failed
// check plus a final pass/total summary.
module tb_sw_led_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] sw;
    logic [3:0] led;
    logic       led_hb;
    logic [3:0] press_pulse;
    logic [7:0] mode;

    int total;
    int fails;
    int ecnt;

    sw_led_ctrl #(
        .NUM_CH          (4),
        .DEBOUNCE_CYCLES (4),
        .BLINK_DIV_W     (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sw          (sw),
        .led         (led),
        .led_hb      (led_hb),
        .press_pulse (press_pulse),
        .mode        (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Heartbeat expectation: counter starts at 0 on release, led_hb lags it by one edge.
    function automatic logic hb_model(input int e);
        if (e == 0) return 1'b0;
        return (((e - 1) % 8) >= 4);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst) begin
            ecnt++;
            chk("led_hb", {31'd0, led_hb}, {31'd0, hb_model(ecnt)});
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic count_pulses(input int n, input int ch, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (press_pulse[ch]) c++;
        end
    endtask

    task automatic count_any(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (press_pulse != 4'd0) c++;
        end
    endtask

    task automatic press(input int ch);
        sw[ch] = 1'b1;
        ticks(12);
        sw[ch] = 1'b0;
        ticks(12);
    endtask

    initial begin
        int c0;
        int c1;
        int highs;
        total = 0;
        fails = 0;
        ecnt  = 0;
        rst   = 1'b1;
        sw    = 4'd0;

        // Power-on reset
        #2;
        chk("por_led", led, 0);
        chk("por_hb", led_hb, 0);
        chk("por_pulse", press_pulse, 0);
        chk("por_mode", mode, 0);
        @(negedge clk);
        rst  = 1'b0;
        ecnt = 0;

        // Test 1: all channels pressed, then async reset with switches held
        sw = 4'hF;
        ticks(10);
        chk("t1_mode_on", mode, 8'h55);
        chk("t1_led_on", led, 4'hF);
        #2;
        rst = 1'b1;
        #1;
        chk("t1_rst_led", led, 0);
        chk("t1_rst_hb", led_hb, 0);
        chk("t1_rst_pulse", press_pulse, 0);
        chk("t1_rst_mode", mode, 0);
        sw = 4'd0;
        @(negedge clk);
        rst  = 1'b0;
        ecnt = 0;
        ticks(16);

        // Test 2: single press latency on channel 0
        sw[0] = 1'b1;
        count_pulses(6, 0, c0);
        chk("t2_early_pulse", c0, 0);
        chk("t2_early_mode", mode, 0);
        tick();
        chk("t2_e7_pulse", press_pulse, 4'b0001);
        chk("t2_e7_mode", mode[1:0], 2'b01);
        chk("t2_e7_led", led[0], 0);
        tick();
        chk("t2_e8_pulse", press_pulse, 0);
        chk("t2_e8_led", led[0], 1);
        count_pulses(12, 0, c0);
        chk("t2_held_pulses", c0, 0);
        sw[0] = 1'b0;
        count_pulses(12, 0, c0);
        chk("t2_release_pulses", c0, 0);
        chk("t2_release_mode", mode[1:0], 2'b01);
        chk("t2_release_led", led[0], 1);

        // Test 3: 3-cycle glitch rejected, 5-cycle pulse accepted once
        sw[1] = 1'b1;
        count_pulses(3, 1, c0);
        sw[1] = 1'b0;
        count_pulses(15, 1, c1);
        chk("t3_glitch_pulses", c0 + c1, 0);
        chk("t3_glitch_mode", mode[3:2], 2'b00);
        sw[1] = 1'b1;
        count_pulses(5, 1, c0);
        sw[1] = 1'b0;
        count_pulses(20, 1, c1);
        chk("t3_accept_pulses", c0 + c1, 1);
        chk("t3_accept_mode", mode[3:2], 2'b01);

        // Test 4: mode cycling on channel 2
        press(2);
        chk("t4_mode_on", mode[5:4], 2'b01);
        chk("t4_led_on", led[2], 1);
        press(2);
        chk("t4_mode_blink", mode[5:4], 2'b10);
        highs = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("t4_blink_vs_hb", led[2], led_hb);
            if (led[2]) highs++;
        end
        chk("t4_blink_duty", highs, 8);
        press(2);
        chk("t4_mode_off", mode[5:4], 2'b00);
        chk("t4_led_off", led[2], 0);
        chk("t4_other_modes", mode, 8'h05);

        // Test 5: simultaneous presses, then bounce on channel 3
        sw = 4'b1001;
        count_any(6, c0);
        chk("t5_early_pulses", c0, 0);
        tick();
        chk("t5_both_pulse", press_pulse, 4'b1001);
        chk("t5_both_mode", mode, 8'h46);
        c1 = 0;
        for (int k = 0; k < 10; k++) begin
            sw[3] = ~sw[3];
            count_any(2, c0);
            c1 += c0;
        end
        chk("t5_bounce_pulses", c1, 0);
        chk("t5_bounce_mode", mode, 8'h46);
        count_any(12, c0);
        chk("t5_steady_pulses", c0, 0);
        sw = 4'd0;
        count_any(12, c0);
        chk("t5_release_pulses", c0, 0);
        chk("t5_release_mode", mode, 8'h46);

        // Test 6: reset mid-debounce restarts counting from release
        sw[0] = 1'b1;
        ticks(3);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_mode", mode, 0);
        chk("t6_rst_led", led, 0);
        @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        ecnt = 0;
        count_pulses(6, 0, c0);
        chk("t6_early_pulses", c0, 0);
        tick();
        chk("t6_e7_pulse", press_pulse, 4'b0001);
        chk("t6_e7_mode", mode, 8'h01);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
